// File: rtl/branch_predictor_pkg.sv
// Shared opcode/rt codes, 2-bit counter encodings and predecode helpers
// for the branch predictor.
package branch_predictor_pkg;

    localparam logic [5:0] op_REGIMM = 6'b000001;
    localparam logic [5:0] op_BEQ    = 6'b000100;
    localparam logic [5:0] op_BNE    = 6'b000101;
    localparam logic [5:0] op_BLEZ   = 6'b000110;
    localparam logic [5:0] op_BGTZ   = 6'b000111;

    localparam logic [4:0] rt_BLTZ   = 5'b00000;
    localparam logic [4:0] rt_BGEZ   = 5'b00001;
    localparam logic [4:0] rt_BLTZAL = 5'b10000;
    localparam logic [4:0] rt_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    function automatic logic is_cond_branch(input logic [31:0] instr);
        logic [5:0] op;
        logic [4:0] rt;
        op = instr[31:26];
        rt = instr[20:16];
        case (op)
            op_BEQ, op_BNE, op_BLEZ, op_BGTZ: is_cond_branch = 1'b1;
            op_REGIMM: is_cond_branch = (rt == rt_BLTZ)   || (rt == rt_BGEZ) ||
                                        (rt == rt_BLTZAL) || (rt == rt_BGEZAL);
            default: is_cond_branch = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        if (taken)
            sat_update = (c == ST) ? ST : c + 2'd1;
        else
            sat_update = (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_counter_table.sv
// 2^INDEX_W x 2-bit saturating counter array: one combinational read port,
// one synchronous read-modify-write update port.
module bp_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int          INDEX_W   = 6,
    parameter logic [1:0]  CNT_RESET = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [1:0]         rd_cnt,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_taken
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [1:0] cnt [DEPTH];

    // No write-to-read bypass: fetch always sees the pre-update value.
    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= CNT_RESET;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic 2-bit branch predictor: predicts in IF, resolves and trains in ID,
// raising a redirect with the correct PC on a wrong guess.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_W   = 6,
    parameter logic [1:0] CNT_RESET = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic [31:0] instrF,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchD,
    input  logic        actual_takenD,
    input  logic [31:0] pc_branchD,
    input  logic [31:0] pc_fallD,
    output logic        mispredictD,
    output logic [31:0] correct_pcD
);

    logic [INDEX_W-1:0] idxF;
    logic               is_branchF;
    logic [1:0]         cntF;
    logic signed [31:0] offsetF;

    logic               validD;
    logic               predD;
    logic [INDEX_W-1:0] idxD;
    logic               updateD;

    // IF: predecode, table lookup and target computation
    assign idxF         = pcF[INDEX_W+1:2];
    assign is_branchF   = is_cond_branch(instrF);
    assign pred_takenF  = is_branchF & cntF[1];
    assign offsetF      = {{14{instrF[15]}}, instrF[15:0], 2'b00};
    assign pred_targetF = pcF + 32'd4 + $unsigned(offsetF);

    bp_counter_table #(
        .INDEX_W   (INDEX_W),
        .CNT_RESET (CNT_RESET)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idxF),
        .rd_cnt   (cntF),
        .wr_en    (updateD),
        .wr_idx   (idxD),
        .wr_taken (actual_takenD)
    );

    // IF -> ID boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validD <= 1'b0;
            predD  <= 1'b0;
            idxD   <= '0;
        end else if (flushD) begin
            validD <= 1'b0;
        end else if (!stallD) begin
            validD <= is_branchF;
            predD  <= pred_takenF;
            idxD   <= idxF;
        end
    end

    // ID: resolution; gating on ~stallD gives one update per branch
    assign updateD     = validD & branchD & ~stallD;
    assign mispredictD = updateD & (predD ^ actual_takenD);
    assign correct_pcD = actual_takenD ? pc_branchD : pc_fallD;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage MIPS pipeline.
- In IF it looks up a 2-bit saturating-counter table indexed by PC and predecodes the fetched instruction, then emits a predicted next-PC redirect for conditional branches.
- In ID it takes the resolved outcome from the decode-stage branch comparator and updates the table. On a wrong guess it raises a redirect with the correct PC.

Parameters:
- INDEX_W, 6, log2 of table entries; index = pcF[INDEX_W+1:2].
- CNT_RESET, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pcF  in  32  PC of instruction being fetched.
- instrF  in  32  fetched instruction word.
- pred_takenF  out  1  IF: instruction is a conditional branch predicted taken.
- pred_targetF  out  32  IF: pcF + 4 + (sign_ext(instrF[15:0]) << 2).
- stallD  in  1  hold the IF/ID stage.
- flushD  in  1  invalidate the IF/ID stage.
- branchD  in  1  ID instruction is a conditional branch.
- actual_takenD  in  1  ID resolved outcome from the branch comparator.
- pc_branchD  in  32  ID branch target from the datapath.
- pc_fallD  in  32  ID fall-through PC from the datapath.
- mispredictD  out  1  ID: prediction was wrong; fetch must redirect.
- correct_pcD  out  32  ID redirect PC, valid when mispredictD = 1.

Behaviour:
- Predecode, combinational. A conditional branch is op 000100 (BEQ), 000101 (BNE), 000110 (BLEZ), 000111 (BGTZ), or op 000001 with rt in {00000, 00001, 10000, 10001}. Any other instruction gives pred_takenF = 0.
- Prediction, combinational from the current table: pred_takenF = is_branchF & table[idxF][1]. pred_targetF is always driven, whatever pred_takenF is.
- F→D register holds validD, predD and idxD:
  - rst → all cleared.
  - flushD → validD = 0 (flush has priority over stall).
  - stallD → hold.
  - otherwise capture is_branchF, pred_takenF and idxF.
- Resolution, combinational:
  - mispredictD = validD & branchD & ~stallD & (predD ^ actual_takenD).
  - correct_pcD = actual_takenD ? pc_branchD : pc_fallD.
- Table update on the rising edge when validD & branchD & ~stallD:
  - taken increments the counter, saturating at 11.
  - not-taken decrements it, saturating at 00.
  - Exactly one update per branch; a stalled branch never updates twice.
- Same-index read and write in one cycle: IF sees the pre-update value. No bypass.
- Reset, asynchronous: every counter = CNT_RESET, validD = 0. So mispredictD = 0 and, with rst held, pred_takenF = 0 (weakly not-taken).
- Reset mid-operation drops any in-flight prediction without updating the table.
- Aliasing is accepted: branches that share an index share one counter. There are no tags.
- Latency:
  - Prediction takes 0 cycles (IF).
  - Resolution takes 1 cycle after fetch (ID).
  - The counter update is visible to fetches one cycle after resolution.

Decomposition:
- Shared defines header: the op_BEQ/op_BNE/op_BGTZ/op_BLEZ/op_REGIMM opcodes, the REGIMM rt codes, and the counter encodings (SNT = 00, WNT = 01, WT = 10, ST = 11).
- One sub-module: bp_counter_table, which holds the 2^INDEX_W × 2-bit array with asynchronous reset, one combinational read port and one synchronous write port doing the saturating increment/decrement.

Test Plan:
- Reset, then fetch BEQ at pcF=0x00400010, imm=0x0004 → pred_takenF=0, pred_targetF=0x00400024. Next cycle, in ID with actual_takenD=1 → mispredictD=1, correct_pcD=pc_branchD; the counter moves 01→10.
- Same branch fetched again → pred_takenF=1. Resolve taken four times → counter saturates at 11 and mispredictD=0 each time.
- From 11, resolve not-taken three times → counter 10, 01, 00. The first two resolutions give mispredictD=1 and correct_pcD=pc_fallD. The third gives mispredictD=0, because its prediction was read at 01 (not-taken).
- Branch in ID with stallD=1 for 3 cycles, then released → mispredictD is low while stalled and the counter changes exactly once.
- flushD asserted alongside a fetched predicted-taken branch → next cycle validD=0: no mispredictD and no table update, even with branchD=1.
- Non-branch instrF (ADDU, op 000000) and REGIMM with rt=00010 → pred_takenF=0. Assert rst mid-sequence → every counter returns to 01 and mispredictD=0 at once, without waiting for a clock.
